// File: rtl/debounce_sync_edge_det_if.sv
// Signal bundle between a raw switch input and its debounced, edge-detected view.
// The master drives the raw level; the slave (the debouncer) returns the conditioned outputs.
interface debounce_sync_edge_det_if #(
  parameter int BOUNCE_W = 8
);
  logic                d_in;
  logic                q_out;
  logic                rise_pulse;
  logic                fall_pulse;
  logic [BOUNCE_W-1:0] bounce_cnt;

  modport master (
    output d_in,
    input  q_out,
    input  rise_pulse,
    input  fall_pulse,
    input  bounce_cnt
  );

  modport slave (
    input  d_in,
    output q_out,
    output rise_pulse,
    output fall_pulse,
    output bounce_cnt
  );
endinterface

// File: rtl/debounce_sync_edge_det.sv
// Two-flop synchroniser plus stability-counter debouncer for a bouncy switch input.
// Produces a registered clean level, one-cycle edge pulses and a saturating bounce counter.
module debounce_sync_edge_det #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8,
  parameter int BOUNCE_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset_in,
  debounce_sync_edge_det_if.slave  bus
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);

  function automatic logic [BOUNCE_W-1:0] sat_inc(input logic [BOUNCE_W-1:0] v);
    return (&v) ? v : v + BOUNCE_W'(1);
  endfunction

  logic                sync1;
  logic                sync2;
  logic                d_sync;
  state_t              state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                level, level_nxt;
  logic                rise, rise_nxt;
  logic                fall, fall_nxt;
  logic [BOUNCE_W-1:0] bounce, bounce_nxt;

  // Synchroniser: the only logic touching the asynchronous input
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.d_in;
      sync2 <= sync1;
    end
  end

  assign d_sync = sync2;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state  <= LOW;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      bounce <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      level  <= level_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
      bounce <= bounce_nxt;
    end
  end

  // Outputs are computed one cycle ahead so q_out and the pulses come straight from flops
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    level_nxt  = level;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    bounce_nxt = bounce;
    case (state)
      LOW: begin
        if (d_sync) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = HIGH;
            level_nxt = 1'b1;
            rise_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = CNT_WIDTH'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (!d_sync) begin
          state_nxt  = LOW;
          cnt_nxt    = '0;
          bounce_nxt = sat_inc(bounce);
        end else if (cnt == LAST_CNT) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      HIGH: begin
        if (!d_sync) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = LOW;
            level_nxt = 1'b0;
            fall_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = CNT_WIDTH'(1);
          end
        end
      end
      WAIT_LOW: begin
        if (d_sync) begin
          state_nxt  = HIGH;
          cnt_nxt    = '0;
          bounce_nxt = sat_inc(bounce);
        end else if (cnt == LAST_CNT) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  assign bus.q_out      = level;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.bounce_cnt = bounce;

endmodule

// File: tb/tb_debounce_sync_edge_det.sv
// Randomised and directed bench for the switch debouncer, checked against a run-length model.
module tb_debounce_sync_edge_det;

  localparam int STABLE = 4;

  logic clk;
  logic reset_in;
  int   n_tests;
  int   n_fail;

  debounce_sync_edge_det_if #(.BOUNCE_W(8)) bus ();
  debounce_sync_edge_det_if #(.BOUNCE_W(2)) bus2 ();

  debounce_sync_edge_det #(.STABLE_CYCLES(STABLE), .CNT_WIDTH(8), .BOUNCE_W(8)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  debounce_sync_edge_det #(.STABLE_CYCLES(STABLE), .CNT_WIDTH(8), .BOUNCE_W(2)) dut_sat (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: d_in seen by the decision logic is the sample from two edges back;
  // q flips once STABLE consecutive decision samples differ from it, a shorter run is a bounce.
  logic       m_q, m_rise, m_fall, ds;
  logic [1:0] hist;
  int         m_run;
  logic [7:0] m_bounce;

  always @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      m_q = 0; m_rise = 0; m_fall = 0; hist = 0; m_run = 0; m_bounce = 0;
    end else begin
      ds     = hist[1];
      hist   = {hist[0], bus.d_in};
      m_rise = 0;
      m_fall = 0;
      if (ds != m_q) begin
        m_run++;
        if (m_run >= STABLE) begin
          m_q = ds; m_rise = ds; m_fall = !ds; m_run = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0;
        if (m_bounce != 8'hFF) m_bounce++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset_in = 0;
    bus.d_in = 0;
    bus2.d_in = 0;
    tick();
    reset_in = 1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_in = 0;
    for (int i = 0; i < 6; i++) begin
      bus.d_in = 1'($urandom);
      tick();
      n_tests++;
      if ({bus.q_out, bus.rise_pulse, bus.fall_pulse, bus.bounce_cnt} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got q=%0b r=%0b f=%0b b=%0d, want all 0",
                 bus.q_out, bus.rise_pulse, bus.fall_pulse, bus.bounce_cnt);
      end
    end
    bus.d_in = 0;
    tick(); tick(); tick();
    reset_in = 1;
    bus.d_in = 1;
    repeat (8) tick();
    n_tests++;
    if (bus.q_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_high: got q=%0b, want 1", bus.q_out);
    end
    #2 reset_in = 0;
    #1;
    n_tests++;
    if ({bus.q_out, bus.rise_pulse, bus.fall_pulse} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: got q=%0b r=%0b f=%0b before clk edge, want 0",
               bus.q_out, bus.rise_pulse, bus.fall_pulse);
    end
    @(negedge clk);
    bus.d_in = 0;
    tick(); tick();
    reset_in = 1;
    repeat (4) tick();
  endtask

  task automatic test_edge(input logic lvl, input string name);
    bus.d_in = lvl;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_tests++;
      if ({bus.q_out, bus.rise_pulse, bus.fall_pulse} !==
          {(e >= 6) ? lvl : !lvl, (e == 6) && lvl, (e == 6) && !lvl}) begin
        n_fail++;
        $display("FAIL %s edge%0d: got q=%0b r=%0b f=%0b, want q=%0b pulse at edge 6",
                 name, e, bus.q_out, bus.rise_pulse, bus.fall_pulse, (e >= 6) ? lvl : !lvl);
      end
      n_tests++;
      if ({bus.q_out, bus.rise_pulse, bus.fall_pulse, bus.bounce_cnt} !==
          {m_q, m_rise, m_fall, m_bounce}) begin
        n_fail++;
        $display("FAIL %s_model edge%0d: got q=%0b r=%0b f=%0b b=%0d, want q=%0b r=%0b f=%0b b=%0d",
                 name, e, bus.q_out, bus.rise_pulse, bus.fall_pulse, bus.bounce_cnt,
                 m_q, m_rise, m_fall, m_bounce);
      end
    end
  endtask

  task automatic test_clean_rise();
    test_edge(1'b1, "clean_rise");
  endtask

  task automatic test_clean_fall();
    test_edge(1'b0, "clean_fall");
  endtask

  task automatic test_bounce();
    logic pat [12] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    reset_pulse();
    for (int i = 0; i < 12; i++) begin
      bus.d_in = pat[i];
      tick();
      n_tests++;
      if ({bus.q_out, bus.rise_pulse, bus.fall_pulse} !== 3'b000) begin
        n_fail++;
        $display("FAIL bounce_level step%0d: got q=%0b r=%0b f=%0b, want 0",
                 i, bus.q_out, bus.rise_pulse, bus.fall_pulse);
      end
    end
    n_tests++;
    if (bus.bounce_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL bounce_count: got %0d, want 2", bus.bounce_cnt);
    end
  endtask

  task automatic test_reset_mid_count();
    reset_pulse();
    bus.d_in = 1;
    tick(); tick(); tick();
    reset_in = 0;
    tick();
    reset_in = 1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_tests++;
      if ({bus.q_out, bus.rise_pulse} !== {e >= 6, e == 6}) begin
        n_fail++;
        $display("FAIL reset_mid edge%0d: got q=%0b r=%0b, want q=%0b r=%0b",
                 e, bus.q_out, bus.rise_pulse, e >= 6, e == 6);
      end
    end
  endtask

  task automatic test_saturation();
    logic pat [5] = '{1, 1, 0, 0, 0};
    reset_pulse();
    n_tests++;
    if (bus2.bounce_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_init: got %0d, want 0", bus2.bounce_cnt);
    end
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 5; i++) begin
        bus2.d_in = pat[i];
        tick();
      end
      n_tests++;
      if ({bus2.q_out, bus2.bounce_cnt} !== {1'b0, 2'((k > 3) ? 3 : k)}) begin
        n_fail++;
        $display("FAIL sat_abort%0d: got q=%0b b=%0d, want q=0 b=%0d",
                 k, bus2.q_out, bus2.bounce_cnt, (k > 3) ? 3 : k);
      end
    end
  endtask

  task automatic test_random();
    logic val = 0;
    reset_pulse();
    for (int r = 0; r < 120; r++) begin
      int len = $urandom_range(1, 7);
      val = !val;
      if (r == 60) begin
        #2 reset_in = 0;
        #1;
        n_tests++;
        if (bus.q_out !== 1'b0 || bus.bounce_cnt !== 8'd0) begin
          n_fail++;
          $display("FAIL rand_async_reset: got q=%0b b=%0d, want 0", bus.q_out, bus.bounce_cnt);
        end
        @(negedge clk);
        reset_in = 1;
      end
      for (int j = 0; j < len; j++) begin
        bus.d_in = val;
        tick();
        n_tests++;
        if ({bus.q_out, bus.rise_pulse, bus.fall_pulse, bus.bounce_cnt} !==
            {m_q, m_rise, m_fall, m_bounce}) begin
          n_fail++;
          $display("FAIL random run%0d: got q=%0b r=%0b f=%0b b=%0d, want q=%0b r=%0b f=%0b b=%0d",
                   r, bus.q_out, bus.rise_pulse, bus.fall_pulse, bus.bounce_cnt,
                   m_q, m_rise, m_fall, m_bounce);
        end
        n_tests++;
        if (bus.rise_pulse && bus.fall_pulse) begin
          n_fail++;
          $display("FAIL random_both_pulses run%0d: got r=1 f=1, want at most one", r);
        end
      end
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_in  = 0;
    bus.d_in  = 0;
    bus2.d_in = 0;
    @(negedge clk);
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_bounce();
    test_reset_mid_count();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
